hash_work_loader: RTL and testbench
===================================

# hash_work_loader

Front-end work receiver for the hashing core. Accepts framed work headers over an 8-bit valid/ready byte stream, reassembles and checks the 608-bit block-without-nonce, and commits it to the hashcore. On each commit it restarts the core's best-hash search. Sits between the host link deserializer and `hashcore`, driving its `block_without_nonce`, `rst_i` and `enable` inputs.

## Interface
- `PAYLOAD_BYTES`, 76: header bytes per frame (608 bits / 8).
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 1024: maximum idle cycles between bytes inside a frame.

- `clk`  in  1  single clock; everything is rising-edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  byte-stream ready.
- `block_o`  out  608  committed block_without_nonce, to hashcore.
- `core_rst_o`  out  1  one-cycle restart pulse, to hashcore `rst_i`.
- `core_enable_o`  out  1  hashcore enable.
- `busy_o`  out  1  frame in progress.
- `frame_ok_o`  out  1  one-cycle pulse when a frame is committed.
- `frame_err_o`  out  1  one-cycle pulse when a frame is discarded.
- `err_code_o`  out  2  last error: 00 none, 01 checksum, 10 timeout; held until the next frame_ok or error.

## Operation
- Frame format: `SYNC_BYTE`, then `PAYLOAD_BYTES` payload bytes sent MSB first (first byte goes to shadow[607:600]), then 1 checksum byte. The checksum is the XOR of all payload bytes.
- A byte transfers when `in_valid && in_ready`.
- FSM states:
  - IDLE:
    - `in_ready`=1.
    - A byte equal to `SYNC_BYTE` moves the FSM to PAYLOAD: byte count cleared, running XOR cleared, timer cleared.
    - Any other byte is dropped silently.
  - PAYLOAD:
    - `in_ready`=1.
    - Each byte shifts into the 608-bit shadow register, XORs into the running checksum, and increments the count.
    - When byte `PAYLOAD_BYTES` transfers, the FSM moves to CHECK.
  - CHECK:
    - `in_ready`=1.
    - If the checksum byte matches: `block_o` <= shadow, `core_rst_o` <= 1, `frame_ok_o` <= 1, `err_code_o` <= 00, state <= COMMIT.
    - If it mismatches: `frame_err_o` <= 1, `err_code_o` <= 01, state <= IDLE; `block_o` is unchanged.
  - COMMIT:
    - `in_ready`=0 for exactly one cycle.
    - `core_rst_o` <= 0, `core_enable_o` <= 1, state <= IDLE.
- Timeout:
  - Applies in PAYLOAD and CHECK.
  - The timer increments on every cycle with no transfer and clears on each transfer.
  - When the timer reaches `TIMEOUT_CYCLES`: `frame_err_o` pulses, `err_code_o` <= 10, state <= IDLE, shadow discarded, `block_o` retained.
- `busy_o` = (state is PAYLOAD or CHECK).
- `core_enable_o` stays 0 from reset until the first successful commit, and stays 1 thereafter until `rst_i`.
- A `SYNC_BYTE` value arriving in PAYLOAD or CHECK is treated as data, not as a resync.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=1.
  - `block_o`=0.
  - `core_rst_o`, `core_enable_o`, `busy_o`, `frame_ok_o`, `frame_err_o` = 0.
  - `err_code_o`=00.
  - Count, XOR and timer = 0.
- Latency:
  - `block_o`, `core_rst_o` and `frame_ok_o` change on the edge that accepts the checksum byte, i.e. they are visible in the following cycle.
  - `core_enable_o` rises one cycle after that.
- `core_rst_o` is high for exactly one cycle, and `block_o` already holds the new value during that cycle.
- A timeout and a transfer on the same cycle: the transfer wins and the timer clears.
- `rst_i` mid-frame aborts the frame with no `frame_err_o` pulse. All outputs return to reset values; `block_o` clears to 0.
- Back-to-back frames: a `SYNC_BYTE` presented during COMMIT waits (`in_ready`=0) and is accepted on the next cycle.
- Sustained throughput is 1 byte/cycle; the minimum frame is 78 transfers plus 1 COMMIT cycle.

## Structure
- Package `hash_work_pkg` holds:
  - the state enum (IDLE, PAYLOAD, CHECK, COMMIT);
  - `BLOCK_BITS`=608;
  - the default `SYNC_BYTE`;
  - the `err_code` localparams.
- One sub-module: `inactivity_timer`, a parameterized saturating counter with clear and enable inputs and a `expired` output. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Everything else (FSM, shadow shift register, XOR accumulator) lives in `hash_work_loader`.

## Test plan
- Good frame: A5, 76×8'h11, checksum 8'h00.
  - `frame_ok_o` pulses once; `block_o` = {76{8'h11}}.
  - `core_rst_o` is high for 1 cycle; `core_enable_o`=1 from the next cycle.
- Bad checksum: A5, 76×8'h11, checksum 8'h01.
  - `frame_err_o` pulses and `err_code_o`=01.
  - `block_o` and `core_enable_o` keep their prior values.
- Timeout: A5, 10 payload bytes, then idle for 1024 cycles.
  - `frame_err_o` pulses and `err_code_o`=10.
  - A following good frame commits normally.
- Noise and stall: bytes 8'h00, 8'h5A before A5 are dropped. `in_valid` is toggled randomly during the payload with gaps under 1024 cycles.
  - The frame commits with the correct `block_o`.
- Reset mid-frame: assert `rst_i` after 40 payload bytes.
  - All outputs return to reset values and no `frame_err_o` pulses.
  - The next good frame is accepted from a fresh A5.
- Back-to-back: two good frames, 76×8'h11 then 76×8'h22, each with checksum 00, streamed with `in_valid` held high.
  - `in_ready` drops for exactly 1 cycle between the frames.
  - `core_rst_o` pulses twice; final `block_o` = {76{8'h22}}.

Source files
------------

// File: rtl/hash_work_pkg.sv
// Shared types and constants for the hashcore work loader.
package hash_work_pkg;

    localparam int         BLOCK_BITS        = 608;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECK,
        ST_COMMIT
    } state_e;

endpackage

// File: rtl/hash_work_loader_if.sv
// Byte-stream valid/ready link from the host deserializer into the loader.
interface hash_work_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/inactivity_timer.sv
// Saturating idle-cycle counter; o_expired holds once LIMIT idle cycles have elapsed.
module inactivity_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_i,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int             CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst_i || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == MAX);
endmodule

// File: rtl/hash_work_loader.sv
// Receives framed 608-bit work headers, verifies the XOR checksum and commits
// them to the hashcore, pulsing its restart and latching its enable.
module hash_work_loader
    import hash_work_pkg::*;
#(
    parameter int         PAYLOAD_BYTES  = 76,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_i,
    hash_work_loader_if.slave     in_if,
    output logic [BLOCK_BITS-1:0] block_o,
    output logic                  core_rst_o,
    output logic                  core_enable_o,
    output logic                  busy_o,
    output logic                  frame_ok_o,
    output logic                  frame_err_o,
    output logic [1:0]            err_code_o
);
    localparam int               CNT_W    = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);

    state_e                r_state;
    logic                  r_in_ready;
    logic [BLOCK_BITS-1:0] r_shadow;
    logic [BLOCK_BITS-1:0] r_block;
    logic [7:0]            r_xor;
    logic [CNT_W-1:0]      r_count;
    logic                  r_core_rst;
    logic                  r_core_en;
    logic                  r_ok;
    logic                  r_err;
    logic [1:0]            r_err_code;

    logic w_xfer;
    logic w_busy;
    logic w_expired;

    assign w_xfer = in_if.in_valid && r_in_ready;
    assign w_busy = (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);

    // Idle time only counts inside a frame; any accepted byte restarts it.
    inactivity_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_i     (rst_i),
        .i_clear   (w_xfer || !w_busy),
        .i_enable  (w_busy && !w_xfer),
        .o_expired (w_expired)
    );

    // NOTE: the shadow is fully overwritten by every frame before it is read,
    // so it carries no reset and stays a plain shift register.
    always_ff @(posedge clk) begin
        if ((r_state == ST_PAYLOAD) && w_xfer) begin
            r_shadow <= {r_shadow[BLOCK_BITS-9:0], in_if.in_data};
        end
    end

    // NOTE: all state and outputs use non-blocking assignment so every branch
    // sees the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_block    <= '0;
            r_xor      <= '0;
            r_count    <= '0;
            r_core_rst <= 1'b0;
            r_core_en  <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_core_rst <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && (in_if.in_data == SYNC_BYTE)) begin
                        r_state <= ST_PAYLOAD;
                        r_count <= '0;
                        r_xor   <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_xfer) begin
                        r_xor   <= r_xor ^ in_if.in_data;
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == LAST_IDX) begin
                            r_state <= ST_CHECK;
                        end
                    end else if (w_expired) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (w_xfer) begin
                        if (in_if.in_data == r_xor) begin
                            r_block    <= r_shadow;
                            r_core_rst <= 1'b1;
                            r_ok       <= 1'b1;
                            r_err_code <= ERR_NONE;
                            r_in_ready <= 1'b0;
                            r_state    <= ST_COMMIT;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_CHECKSUM;
                            r_state    <= ST_IDLE;
                        end
                    end else if (w_expired) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    r_core_en  <= 1'b1;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_if.in_ready = r_in_ready;
    assign block_o        = r_block;
    assign core_rst_o     = r_core_rst;
    assign core_enable_o  = r_core_en;
    assign busy_o         = w_busy;
    assign frame_ok_o     = r_ok;
    assign frame_err_o    = r_err;
    assign err_code_o     = r_err_code;
endmodule

// File: tb/tb_hash_work_loader.sv
// Randomised scoreboard bench for hash_work_loader: stimulus pushes expected
// commit/discard events, a negedge monitor pops and compares them.
module tb_hash_work_loader;
    import hash_work_pkg::*;

    typedef struct {
        bit           ok;
        logic [1:0]   code;
        logic [607:0] blk;
        bit           en;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [607:0] block_o;
    logic         core_rst_o, core_enable_o, busy_o, frame_ok_o, frame_err_o;
    logic [1:0]   err_code_o;

    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         q[$];
    logic [607:0] m_block = '0;
    bit           m_en    = 1'b0;
    logic [7:0]   payload[76];

    always #5 clk = ~clk;

    hash_work_loader_if bus ();

    hash_work_loader dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .in_if         (bus),
        .block_o       (block_o),
        .core_rst_o    (core_rst_o),
        .core_enable_o (core_enable_o),
        .busy_o        (busy_o),
        .frame_ok_o    (frame_ok_o),
        .frame_err_o   (frame_err_o),
        .err_code_o    (err_code_o)
    );

    task automatic check(input string name, input logic [607:0] act, input logic [607:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        bit done;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        done = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            if (bus.in_ready) done = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!done) check("in_ready stuck low", 608'(bus.in_ready), 608'(1));
    endtask

    task automatic fill_const(input logic [7:0] b);
        for (int i = 0; i < 76; i++) payload[i] = b;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 76; i++) payload[i] = 8'($urandom);
    endtask

    // Builds the frame from the global payload; the reference block places
    // byte i at bits [607-8i -: 8] and the checksum is the XOR of all bytes.
    task automatic send_frame(input bit bad, input int max_gap);
        logic [7:0]   cks;
        logic [607:0] blk;
        exp_t         e;
        cks = 8'h00;
        blk = '0;
        for (int i = 0; i < 76; i++) begin
            cks = cks ^ payload[i];
            blk[607-8*i -: 8] = payload[i];
        end
        if (bad) cks = cks ^ 8'h01;
        e.ok = !bad;
        e.en = m_en;
        if (bad) begin
            e.code = ERR_CHECKSUM;
            e.blk  = m_block;
        end else begin
            e.code  = ERR_NONE;
            e.blk   = blk;
            m_block = blk;
            m_en    = 1'b1;
        end
        send_byte(8'hA5, max_gap);
        check("busy after sync", 608'(busy_o), 608'(1));
        for (int i = 0; i < 76; i++) send_byte(payload[i], max_gap);
        q.push_back(e);
        send_byte(cks, max_gap);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " block_o"}, block_o, '0);
        check({tag, " outputs"},
              608'({core_rst_o, core_enable_o, busy_o, frame_ok_o, frame_err_o, err_code_o, bus.in_ready}),
              608'(8'b0000_0001));
    endtask

    // Monitor: every ok/err pulse must match the head of the scoreboard.
    initial begin
        bit   after_ok;
        exp_t e;
        after_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                after_ok = 1'b0;
            end else begin
                if (after_ok) begin
                    check("enable after commit", 608'(core_enable_o), 608'(1));
                    check("core_rst one cycle", 608'(core_rst_o), 608'(0));
                    check("in_ready after commit", 608'(bus.in_ready), 608'(1));
                    after_ok = 1'b0;
                end
                if (frame_ok_o || frame_err_o || core_rst_o || !bus.in_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected event", 608'({frame_ok_o, frame_err_o, core_rst_o, !bus.in_ready}), '0);
                    end else if (frame_ok_o || frame_err_o) begin
                        e = q.pop_front();
                        check("event kind", 608'({frame_ok_o, frame_err_o}), 608'({e.ok, !e.ok}));
                        check("block_o", block_o, e.blk);
                        check("err_code", 608'(err_code_o), 608'(e.code));
                        if (e.ok) begin
                            check("core_rst with ok", 608'(core_rst_o), 608'(1));
                            check("in_ready in commit", 608'(bus.in_ready), 608'(0));
                            after_ok = 1'b1;
                        end else begin
                            check("enable kept on err", 608'(core_enable_o), 608'(e.en));
                            check("no core_rst on err", 608'(core_rst_o), 608'(0));
                        end
                    end else begin
                        check("stray core_rst/in_ready", 608'({core_rst_o, !bus.in_ready}), '0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_i = 1'b0;
        @(negedge clk);

        // Good frame, then bad checksum.
        fill_const(8'h11);
        send_frame(1'b0, 0);
        repeat (3) @(negedge clk);
        fill_const(8'h11);
        send_frame(1'b1, 0);
        repeat (3) @(negedge clk);
        check("busy idle after err", 608'(busy_o), 608'(0));

        // Timeout after 10 payload bytes.
        send_byte(8'hA5, 0);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
        e.ok = 1'b0; e.code = ERR_TIMEOUT; e.blk = m_block; e.en = m_en;
        q.push_back(e);
        repeat (1100) @(negedge clk);
        check("err_code held timeout", 608'(err_code_o), 608'(ERR_TIMEOUT));
        check("busy idle after timeout", 608'(busy_o), 608'(0));
        fill_const(8'h33);
        send_frame(1'b0, 0);
        repeat (3) @(negedge clk);

        // Noise before sync, then a stalled random frame.
        send_byte(8'h00, 3);
        send_byte(8'h5A, 3);
        check("noise dropped", 608'(busy_o), 608'(0));
        fill_rand();
        send_frame(1'b0, 20);
        repeat (3) @(negedge clk);

        // Reset after 40 payload bytes.
        send_byte(8'hA5, 0);
        for (int i = 0; i < 40; i++) send_byte(8'($urandom), 2);
        rst_i = 1'b1;
        @(negedge clk);
        check_reset_state("mid-frame reset");
        rst_i   = 1'b0;
        m_block = '0;
        m_en    = 1'b0;
        @(negedge clk);
        fill_const(8'h44);
        send_frame(1'b0, 0);
        repeat (3) @(negedge clk);

        // Back-to-back frames with in_valid held high.
        fill_const(8'h11);
        send_frame(1'b0, 0);
        fill_const(8'h22);
        send_frame(1'b0, 0);
        repeat (3) @(negedge clk);
        check("final block 22", block_o, {76{8'h22}});

        // A few random frames, some corrupted.
        for (int k = 0; k < 4; k++) begin
            fill_rand();
            send_frame(k[0], 4);
        end
        repeat (5) @(negedge clk);
        check("scoreboard drained", 608'(q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
